// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// readM/inputReady handshake and holds it in the IR until downstream advances.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        readM,
    output logic [15:0] address,
    input  logic [15:0] mem_data,
    input  logic        inputReady,
    input  logic        advance,
    input  logic        jump,
    input  logic [11:0] jump_target,
    output logic [15:0] instruction,
    output logic [3:0]  opcode,
    output logic [5:0]  function_code,
    output logic        inst_valid,
    output logic [15:0] pc,
    output logic [15:0] num_inst
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] num_q, num_d;
    logic [15:0] pc_plus1_s;

    assign pc_plus1_s = pc_q + 16'd1;

    // Next-state logic: fetch in FETCH, retire and redirect the PC in HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        num_d   = num_q;
        case (state_q)
            ST_FETCH: begin
                if (inputReady) begin
                    ir_d    = mem_data;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    num_d   = num_q + 16'd1;
                    state_d = ST_FETCH;
                    // The jump keeps the upper nibble of the already-incremented PC.
                    if (jump) begin
                        pc_d = {pc_plus1_s[15:12], jump_target};
                    end else begin
                        pc_d = pc_plus1_s;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers with asynchronous clear of any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            num_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            num_q   <= num_d;
        end
    end

    // readM is gated by reset_n so it drops the instant reset is applied.
    assign readM         = (state_q == ST_FETCH) && reset_n;
    assign inst_valid    = (state_q == ST_HOLD);
    assign address       = pc_q;
    assign pc            = pc_q;
    assign instruction   = ir_q;
    assign opcode        = ir_q[15:12];
    assign function_code = ir_q[5:0];
    assign num_inst      = num_q;

endmodule
